// File: rtl/fsm_input_cond.sv
// Two-channel input conditioner: synchronizer, stability counter and debounced level per channel.
// Optional build macro FSM_INPUT_COND_PULSE_EN turns i/j into one-cycle rising-edge pulses.
module fsm_input_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic raw_j,
  output logic i,
  output logic j,
  output logic chg
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Channel 0 carries i, channel 1 carries j.
  logic [1:0]                  w_raw;
  logic [1:0]                  w_sync;
  logic [1:0]                  w_accept;
  logic [1:0][SYNC_STAGES-1:0] r_sync;
  logic [1:0][CNT_W-1:0]       r_cnt;
  logic [1:0]                  r_db;
  logic                        r_chg;

  assign w_raw = {raw_j, raw_i};

  always_comb begin
    w_sync   = '0;
    w_accept = '0;
    for (int ch = 0; ch < 2; ch++) begin
      w_sync[ch]   = r_sync[ch][SYNC_STAGES-1];
      w_accept[ch] = (w_sync[ch] != r_db[ch]) && (r_cnt[ch] == CNT_MAX);
    end
  end

  // A mismatch must persist for DB_CYCLES evaluations; any match restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_db   <= '0;
      r_chg  <= 1'b0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], w_raw[ch]};
        if (w_sync[ch] == r_db[ch]) begin
          r_cnt[ch] <= '0;
        end else if (w_accept[ch]) begin
          r_db[ch]  <= w_sync[ch];
          r_cnt[ch] <= '0;
        end else begin
          r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
        end
      end
      r_chg <= |w_accept;
    end
  end

`ifdef FSM_INPUT_COND_PULSE_EN
  logic [1:0] r_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= w_accept & w_sync;
    end
  end

  assign i = r_pulse[0];
  assign j = r_pulse[1];
`else
  assign i = r_db[0];
  assign j = r_db[1];
`endif

  assign chg = r_chg;

endmodule

// File: tb/tb_fsm_input_cond.sv
// Bench for fsm_input_cond: window-based reference model, per-cycle compare, directed latency checks.
module tb_fsm_input_cond;

  localparam int SS = 2;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_i = 1'b0;
  logic raw_j = 1'b0;
  logic i, j, chg;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  fsm_input_cond #(.SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .raw_i(raw_i), .raw_j(raw_j),
    .i(i), .j(j), .chg(chg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw history per channel, newest at index 0. At an edge the debouncer
  // sees the raw value sampled SS edges earlier; a new level is accepted when the
  // last DB such values all disagree with the current level.
  bit hi[$];
  bit hj[$];
  bit m_db_i, m_db_j, m_i, m_j, m_chg;

  function automatic bit window_is(input bit h[$], input bit v);
    for (int k = SS; k < SS + DB; k++)
      if (h[k] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit a_i, a_j;
    if (!rst) begin
      hi = {};
      hj = {};
      for (int k = 0; k < SS + DB; k++) begin
        hi.push_back(1'b0);
        hj.push_back(1'b0);
      end
      m_db_i = 0; m_db_j = 0; m_i = 0; m_j = 0; m_chg = 0;
    end else begin
      hi.push_front(raw_i);
      hj.push_front(raw_j);
      void'(hi.pop_back());
      void'(hj.pop_back());
      a_i = window_is(hi, !m_db_i);
      a_j = window_is(hj, !m_db_j);
      if (a_i) m_db_i = !m_db_i;
      if (a_j) m_db_j = !m_db_j;
      m_chg = a_i | a_j;
`ifdef FSM_INPUT_COND_PULSE_EN
      m_i = a_i & m_db_i;
      m_j = a_j & m_db_j;
`else
      m_i = m_db_i;
      m_j = m_db_j;
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_i", int'(i), int'(m_i));
      check("cmp_j", int'(j), int'(m_j));
      check("cmp_chg", int'(chg), int'(m_chg));
    end
  end

  // Count edges until the selected output (0:i 1:j 2:chg) is seen high; 99 on timeout.
  task automatic wait_sig(input int which, output int n);
    bit hit;
    hit = 0;
    n = 0;
    while (!hit && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      case (which)
        0: hit = i;
        1: hit = j;
        default: hit = chg;
      endcase
    end
    if (!hit) n = 99;
  endtask

  bit seen_j, seen_chg;

  task automatic tick();
    @(negedge clk);
    if (j) seen_j = 1;
    if (chg) seen_chg = 1;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit vi, input bit vj);
    @(posedge clk);
    #2;
    raw_i = vi;
    raw_j = vj;
  endtask

  initial begin
    int n;
    int hold_i, hold_j;
    #1;
    rst = 1'b0;
    raw_i = 1'b1;
    raw_j = 1'b1;
    cmp_en = 1'b1;

    repeat (10) begin
      @(negedge clk);
      check("rst_i", int'(i), 0);
      check("rst_j", int'(j), 0);
      check("rst_chg", int'(chg), 0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    wait_sig(0, n);
    check("release_latency", n, SS + DB);
    check("release_j", int'(j), 1);
    check("release_chg", int'(chg), 1);
    @(negedge clk);
    check("release_chg_off", int'(chg), 0);

    drive(0, 0);
    repeat (12) tick();
    drive(1, 0);
    wait_sig(0, n);
    check("step_rise_latency", n, SS + DB);
    check("step_rise_chg", int'(chg), 1);
    @(negedge clk);
    check("step_rise_chg_off", int'(chg), 0);
    repeat (10) tick();
    drive(0, 0);
    wait_sig(2, n);
    check("step_fall_latency", n, SS + DB);
`ifndef FSM_INPUT_COND_PULSE_EN
    check("step_fall_i", int'(i), 0);
`endif
    repeat (12) tick();

    seen_j = 0;
    seen_chg = 0;
    repeat (5) begin
      raw_j = 1'b1;
      repeat (3) tick();
      raw_j = 1'b0;
      repeat (3) tick();
    end
    repeat (8) tick();
    check("glitch_j", int'(seen_j), 0);
    check("glitch_chg", int'(seen_chg), 0);
    seen_j = 0;
    raw_j = 1'b1;
    repeat (6) tick();
    raw_j = 1'b0;
    repeat (4) tick();
    check("long_pulse_j", int'(seen_j), 1);
    repeat (12) tick();

    drive(1, 1);
    wait_sig(0, n);
    check("simul_latency", n, SS + DB);
    check("simul_j", int'(j), 1);
    check("simul_chg", int'(chg), 1);
    @(negedge clk);
    check("simul_chg_off", int'(chg), 0);

    drive(0, 0);
    repeat (12) tick();
    drive(1, 0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    wait_sig(0, n);
    check("midreset_latency", n, SS + DB);

    hold_i = 0;
    hold_j = 0;
    repeat (3000) begin
      @(posedge clk);
      #2;
      if (hold_i == 0) begin
        raw_i = 1'($urandom_range(0, 1));
        hold_i = $urandom_range(1, 8);
      end
      if (hold_j == 0) begin
        raw_j = 1'($urandom_range(0, 1));
        hold_j = $urandom_range(1, 8);
      end
      hold_i--;
      hold_j--;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2;
        rst = 1'b1;
      end
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
